// File: rtl/eth_pcs_66_64_dec.sv
// 64b/66b receive decoder: rebuilds 64-bit blocks from 32-bit transfers, classifies
// them, runs the receive state machine and presents the result as 4-lane XGMII slices.
package eth_pcs_params;
  localparam int N_CHANNELS      = 4;
  localparam int W_BYTE          = 8;
  localparam int W_DATA          = 32;
  localparam int W_SYNC          = 2;
  localparam int N_TRANS_PER_BLK = 2;
  localparam int W_TRANS_PER_BLK = 1;
  localparam int W_PLD_BLK       = 64;
  localparam int N_LANES         = W_PLD_BLK / W_BYTE;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] C_TYPE  = 8'h1E;
  localparam logic [7:0] S0_TYPE = 8'h78;
  localparam logic [7:0] S4_TYPE = 8'h33;
  localparam logic [7:0] T0_TYPE = 8'h87;
  localparam logic [7:0] T1_TYPE = 8'h99;
  localparam logic [7:0] T2_TYPE = 8'hAA;
  localparam logic [7:0] T3_TYPE = 8'hB4;
  localparam logic [7:0] T4_TYPE = 8'hCC;
  localparam logic [7:0] T5_TYPE = 8'hD2;
  localparam logic [7:0] T6_TYPE = 8'hE1;
  localparam logic [7:0] T7_TYPE = 8'hFF;

  localparam logic [6:0] CODE_IDLE = 7'h00;

  localparam logic [7:0] SYM_IDLE  = 8'h07;
  localparam logic [7:0] SYM_START = 8'hFB;
  localparam logic [7:0] SYM_TERM  = 8'hFD;
  localparam logic [7:0] SYM_ERR   = 8'hFE;

  typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;
  typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_t;
endpackage

module eth_pcs_66_64_dec
  import eth_pcs_params::*;
(
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_clk_en,
  input  logic [W_TRANS_PER_BLK-1:0]     i_trans_cnt,
  input  logic                           i_blk_lock,
  input  logic [W_SYNC-1:0]              i_sync_data,
  input  logic [W_DATA-1:0]              i_pld_data,
  output logic [N_CHANNELS-1:0]          o_xgmii_ctrl,
  output logic [N_CHANNELS*W_BYTE-1:0]   o_xgmii_data,
  output logic [7:0]                     o_err_cnt
);

  localparam int W_SLICE = N_CHANNELS * W_BYTE;
  localparam logic [W_TRANS_PER_BLK-1:0] LAST_TRANS = W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1);

  logic [W_DATA-1:0]    slices_q [N_TRANS_PER_BLK-1];
  logic [W_SYNC-1:0]    sync_q;
  logic                 have_first_q;
  rx_state_t            state_q, state_d;
  logic [W_PLD_BLK-1:0] out_data_q;
  logic [N_LANES-1:0]   out_ctrl_q;
  logic [7:0]           err_cnt_q;

  logic [W_PLD_BLK-1:0] blk;
  blk_class_t           dec_class;
  logic [W_PLD_BLK-1:0] dec_data;
  logic [N_LANES-1:0]   dec_ctrl;
  logic                 codes_idle;
  logic                 is_term;
  logic [2:0]           term_n;

  // Stored slices plus the live one form the complete block at the decode transfer.
  always_comb begin
    blk = '0;
    for (int k = 0; k < N_TRANS_PER_BLK - 1; k++)
      blk[k*W_DATA +: W_DATA] = slices_q[k];
    blk[W_PLD_BLK-W_DATA +: W_DATA] = i_pld_data;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_class  = BLK_E;
    dec_data   = {N_LANES{SYM_ERR}};
    dec_ctrl   = '1;
    codes_idle = 1'b1;
    is_term    = 1'b1;
    term_n     = 3'd0;

    for (int i = 0; i < N_LANES; i++)
      if (blk[W_BYTE + 7*i +: 7] != CODE_IDLE) codes_idle = 1'b0;

    case (blk[7:0])
      T0_TYPE: term_n = 3'd0;
      T1_TYPE: term_n = 3'd1;
      T2_TYPE: term_n = 3'd2;
      T3_TYPE: term_n = 3'd3;
      T4_TYPE: term_n = 3'd4;
      T5_TYPE: term_n = 3'd5;
      T6_TYPE: term_n = 3'd6;
      T7_TYPE: term_n = 3'd7;
      default: is_term = 1'b0;
    endcase

    if (sync_q == SYNC_DATA) begin
      dec_class = BLK_D;
      dec_data  = blk;
      dec_ctrl  = '0;
    end else if (sync_q == SYNC_CTRL) begin
      if (blk[7:0] == C_TYPE && codes_idle) begin
        dec_class = BLK_C;
        dec_data  = {N_LANES{SYM_IDLE}};
        dec_ctrl  = '1;
      end else if (blk[7:0] == S0_TYPE) begin
        dec_class = BLK_S;
        dec_data  = {blk[W_PLD_BLK-1:W_BYTE], SYM_START};
        dec_ctrl  = 8'h01;
      end else if (blk[7:0] == S4_TYPE) begin
        dec_class = BLK_S;
        dec_data  = {blk[W_PLD_BLK-1:5*W_BYTE], SYM_START, {4{SYM_IDLE}}};
        dec_ctrl  = 8'h1F;
      end else if (is_term) begin
        dec_class = BLK_T;
        for (int j = 0; j < N_LANES; j++) begin
          dec_data[j*W_BYTE +: W_BYTE] = (j == int'(term_n)) ? SYM_TERM : SYM_IDLE;
          dec_ctrl[j] = (j >= int'(term_n));
        end
        // Terminate data bytes sit one byte above their lane, behind the type field.
        for (int j = 0; j < N_LANES - 1; j++)
          if (j < int'(term_n)) dec_data[j*W_BYTE +: W_BYTE] = blk[(j+1)*W_BYTE +: W_BYTE];
      end
    end
  end

  always_comb begin
    state_d = RX_E;
    case (state_q)
      RX_D: begin
        if (dec_class == BLK_D)      state_d = RX_D;
        else if (dec_class == BLK_T) state_d = RX_T;
      end
      RX_E: begin
        case (dec_class)
          BLK_C:   state_d = RX_C;
          BLK_D:   state_d = RX_D;
          BLK_T:   state_d = RX_T;
          BLK_S:   state_d = RX_D;
          default: state_d = RX_E;
        endcase
      end
      default: begin
        if (dec_class == BLK_C)      state_d = RX_C;
        else if (dec_class == BLK_S) state_d = RX_D;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= RX_INIT;
      sync_q       <= '0;
      have_first_q <= 1'b0;
      // NOTE: the slice store is small and must read as zero after reset, so it is reset like any other register.
      for (int k = 0; k < N_TRANS_PER_BLK - 1; k++) slices_q[k] <= '0;
      out_data_q   <= {N_LANES{SYM_IDLE}};
      out_ctrl_q   <= '1;
      err_cnt_q    <= '0;
    end else if (i_clk_en) begin
      for (int k = 0; k < N_TRANS_PER_BLK - 1; k++)
        if (i_trans_cnt == W_TRANS_PER_BLK'(k)) slices_q[k] <= i_pld_data;
      if (i_trans_cnt == '0) begin
        sync_q       <= i_sync_data;
        have_first_q <= 1'b1;
      end
      if (i_trans_cnt == LAST_TRANS) begin
        have_first_q <= 1'b0;
        if (!i_blk_lock) begin
          state_q    <= RX_INIT;
          out_data_q <= {N_LANES{SYM_IDLE}};
          out_ctrl_q <= '1;
        end else if (have_first_q) begin
          // A block whose first transfer was lost to reset is dropped, not decoded.
          state_q <= state_d;
          if (state_d == RX_E) begin
            out_data_q <= {N_LANES{SYM_ERR}};
            out_ctrl_q <= '1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            out_data_q <= dec_data;
            out_ctrl_q <= dec_ctrl;
          end
        end
      end
    end
  end

  always_comb begin
    o_xgmii_data = out_data_q[W_SLICE-1:0];
    o_xgmii_ctrl = out_ctrl_q[N_CHANNELS-1:0];
    for (int k = 1; k < N_TRANS_PER_BLK; k++) begin
      if (i_trans_cnt == W_TRANS_PER_BLK'(k)) begin
        o_xgmii_data = out_data_q[k*W_SLICE +: W_SLICE];
        o_xgmii_ctrl = out_ctrl_q[k*N_CHANNELS +: N_CHANNELS];
      end
    end
  end

  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_eth_pcs_66_64_dec.sv
// Scoreboard bench for eth_pcs_66_64_dec: a driver pushes model predictions per block,
// a monitor pops them on the following block and compares every transfer.
module tb_eth_pcs_66_64_dec;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_clk_en;
  logic [0:0]  i_trans_cnt;
  logic        i_blk_lock;
  logic [1:0]  i_sync_data;
  logic [31:0] i_pld_data;
  logic [3:0]  o_xgmii_ctrl;
  logic [31:0] o_xgmii_data;
  logic [7:0]  o_err_cnt;

  eth_pcs_66_64_dec dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clk_en     (i_clk_en),
    .i_trans_cnt  (i_trans_cnt),
    .i_blk_lock   (i_blk_lock),
    .i_sync_data  (i_sync_data),
    .i_pld_data   (i_pld_data),
    .o_xgmii_ctrl (o_xgmii_ctrl),
    .o_xgmii_data (o_xgmii_data),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic [7:0]  err;
  } exp_t;

  localparam logic [63:0] C_PL = {56'h0, 8'h1E};

  logic [7:0] t_types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  exp_t sb_q [$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   need_pop = 1'b1;
  bit   stall_on = 1'b0;
  byte  m_state  = "I";
  int   m_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a block means on the wire, independent of any decoder structure.
  function automatic void classify(input logic [1:0] sy, input logic [63:0] pl,
                                   output byte cls, output logic [63:0] lanes,
                                   output logic [7:0] ctrl);
    cls   = "E";
    lanes = '0;
    ctrl  = 8'hFF;
    if (sy == 2'b01) begin
      cls = "D"; lanes = pl; ctrl = 8'h00;
    end else if (sy == 2'b10) begin
      if (pl[7:0] == 8'h1E && pl[63:8] == 56'h0) begin
        cls = "C"; lanes = {8{8'h07}};
      end else if (pl[7:0] == 8'h78) begin
        cls = "S"; lanes = {pl[63:8], 8'hFB}; ctrl = 8'h01;
      end else if (pl[7:0] == 8'h33) begin
        cls = "S"; lanes = {pl[63:40], 8'hFB, {4{8'h07}}}; ctrl = 8'h1F;
      end else begin
        for (int n = 0; n < 8; n++) begin
          if (pl[7:0] == t_types[n]) begin
            cls   = "T";
            ctrl  = 8'hFF << n;
            lanes = pl >> 8;
            for (int j = 0; j < 8; j++) begin
              if (j == n)     lanes[8*j +: 8] = 8'hFD;
              else if (j > n) lanes[8*j +: 8] = 8'h07;
            end
          end
        end
      end
    end
  endfunction

  task automatic model_block(input logic [1:0] sy, input logic [63:0] pl, input logic lk);
    byte         cls;
    byte         nxt;
    logic [63:0] lanes;
    logic [7:0]  ctrl;
    exp_t        e;
    if (!lk) begin
      m_state = "I";
      e.data  = {8{8'h07}};
      e.ctrl  = 8'hFF;
    end else begin
      classify(sy, pl, cls, lanes, ctrl);
      if (m_state == "D")      nxt = (cls == "D") ? "D" : (cls == "T") ? "T" : "E";
      else if (m_state == "E") nxt = (cls == "S") ? "D" : cls;
      else                     nxt = (cls == "C") ? "C" : (cls == "S") ? "D" : "E";
      m_state = nxt;
      if (nxt == "E") begin
        if (m_err < 255) m_err++;
        e.data = {8{8'hFE}};
        e.ctrl = 8'hFF;
      end else begin
        e.data = lanes;
        e.ctrl = ctrl;
      end
    end
    e.err = 8'(m_err);
    sb_q.push_back(e);
  endtask

  task automatic xfer(input logic en, input logic [0:0] tc, input logic [1:0] sy,
                      input logic [31:0] pd, input logic lk);
    i_clk_en    = en;
    i_trans_cnt = tc;
    i_sync_data = sy;
    i_pld_data  = pd;
    i_blk_lock  = lk;
    @(posedge i_clk);
    #1;
  endtask

  task automatic maybe_stall();
    if (stall_on && $urandom_range(0, 3) == 0)
      xfer(1'b0, 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic send_block(input logic [1:0] sy, input logic [63:0] pl, input logic lk);
    maybe_stall();
    xfer(1'b1, 1'b0, sy, pl[31:0], lk);
    maybe_stall();
    model_block(sy, pl, lk);
    xfer(1'b1, 1'b1, 2'($urandom), pl[63:32], lk);
  endtask

  task automatic do_reset(input int cycles);
    exp_t e;
    sb_q.delete();
    m_state = "I";
    m_err   = 0;
    e.data  = {8{8'h07}};
    e.ctrl  = 8'hFF;
    e.err   = 8'h00;
    sb_q.push_back(e);
    i_reset_n = 1'b0;
    repeat (cycles) xfer(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
    i_reset_n = 1'b1;
  endtask

  task automatic rand_block(output logic [1:0] sy, output logic [63:0] pl);
    logic [63:0] r;
    r = {$urandom, $urandom};
    sy = 2'b10;
    case ($urandom_range(0, 9))
      0, 1, 2: pl = C_PL;
      3:       pl = {r[63:8], 8'h78};
      4:       pl = {r[63:40], 32'h0, 8'h33};
      5, 6:    begin sy = 2'b01; pl = r; end
      7:       pl = {r[63:8], t_types[$urandom_range(0, 7)]};
      8:       begin sy = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11; pl = r; end
      default: pl = r;
    endcase
  endtask

  initial begin : monitor
    int sl;
    forever begin
      @(negedge i_clk);
      if (i_reset_n !== 1'b1) begin
        need_pop = 1'b1;
      end else begin
        if (need_pop && i_trans_cnt == 1'b0) begin
          if (sb_q.size() > 0) begin
            cur      = sb_q.pop_front();
            need_pop = 1'b0;
          end else begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: no expected block queued at %0t", $time);
          end
        end
        if (!need_pop) begin
          sl = int'(i_trans_cnt);
          check("xgmii_data", 64'(o_xgmii_data), 64'(32'(cur.data >> (32*sl))));
          check("xgmii_ctrl", 64'(o_xgmii_ctrl), 64'(4'(cur.ctrl >> (4*sl))));
          check("err_cnt",    64'(o_err_cnt),    64'(cur.err));
        end
        if (i_clk_en && i_trans_cnt == 1'b1) need_pop = 1'b1;
      end
    end
  end

  initial begin : driver
    logic [1:0]  sy;
    logic [63:0] pl;
    do_reset(3);

    repeat (4) send_block(2'b10, C_PL, 1'b1);

    send_block(2'b10, 64'h5555555555555578, 1'b1);
    send_block(2'b01, 64'h07060504030201D5, 1'b1);
    send_block(2'b10, {32'h9ABCDEF0, 8'hCC, 8'hBB, 8'hAA, 8'hB4}, 1'b1);
    send_block(2'b10, C_PL, 1'b1);

    send_block(2'b11, C_PL, 1'b1);
    send_block(2'b10, C_PL, 1'b1);

    send_block(2'b01, 64'h0123456789ABCDEF, 1'b1);
    send_block(2'b10, C_PL, 1'b1);

    send_block(2'b10, C_PL, 1'b0);
    send_block(2'b10, C_PL, 1'b1);

    stall_on = 1'b1;
    send_block(2'b10, {24'hC0FFEE, 32'h0, 8'h33}, 1'b1);
    send_block(2'b01, 64'hFEEDFACECAFEBEEF, 1'b1);
    send_block(2'b10, {56'h0000112233, 8'hFF}, 1'b1);
    send_block(2'b10, {56'h0, 8'h87}, 1'b1);

    send_block(2'b10, C_PL, 1'b1);
    xfer(1'b1, 1'b0, 2'b01, 32'h11111111, 1'b1);
    do_reset(1);
    xfer(1'b1, 1'b1, 2'b00, 32'h22222222, 1'b1);
    send_block(2'b10, C_PL, 1'b1);
    send_block(2'b10, C_PL, 1'b1);

    repeat (400) begin
      rand_block(sy, pl);
      send_block(sy, pl, ($urandom_range(0, 15) != 0));
    end

    repeat (300) send_block(2'b00, {$urandom, $urandom}, 1'b1);
    send_block(2'b10, C_PL, 1'b1);
    send_block(2'b10, C_PL, 1'b1);

    stall_on = 1'b0;
    xfer(1'b1, 1'b0, 2'b10, 32'h0, 1'b1);
    xfer(1'b0, 1'b0, 2'b10, 32'h0, 1'b1);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_pcs_66_64_dec.md
ETH_PCS_66_64_DEC -- requirements
Module: eth_pcs_66_64_dec

Interface
REQ-001 SHALL use package parameters: N_CHANNELS=4, W_BYTE=8, W_DATA=32, W_SYNC=2, N_TRANS_PER_BLK=2, W_TRANS_PER_BLK=1, W_PLD_BLK=64; type/code/symbol constants from eth_pcs_params.
REQ-002 SHALL have one clock and a synchronous, active-low reset:
- i_clk  in  1  sole clock, rising edge
- i_reset_n  in  1  synchronous reset, active low
REQ-003 SHALL have these other ports:
- i_clk_en  in  1  transfer qualifier; no state change when low
- i_trans_cnt  in  W_TRANS_PER_BLK  transfer index in block, 0 first
- i_blk_lock  in  1  block lock from sync FSM
- i_sync_data  in  W_SYNC  sync header, valid at i_trans_cnt==0
- i_pld_data  in  W_DATA  payload slice i_trans_cnt of 64-bit block
- o_xgmii_ctrl  out  N_CHANNELS  per-lane control flag
- o_xgmii_data  out  N_CHANNELS x W_BYTE  per-lane byte
- o_err_cnt  out  8  saturating count of blocks decoded as error

Function
REQ-004 SHALL assemble a 64-bit block: transfer k supplies payload bits [32k+31:32k]; bits [7:0] are the block type field for control blocks.
REQ-005 SHALL capture the sync header on the enabled transfer with i_trans_cnt==0, and hold it for the whole block.
REQ-006 SHALL decode on the enabled transfer with i_trans_cnt==N_TRANS_PER_BLK-1, using the current slice combined with the stored slices. The decoded block SHALL be registered. Output slice k equals decoded lanes [4k+3:4k], selected by the live i_trans_cnt. Latency is exactly one block (N_TRANS_PER_BLK enabled transfers).
REQ-007 SHALL classify each block:
- D: sync==SYNC_DATA; lanes 0..7 are payload bytes 0..7, ctrl=0.
- C: C_TYPE with all eight 7-bit codes ==CODE_IDLE; lanes = SYM_IDLE, ctrl=1.
- S: S0_TYPE gives lane0=SYM_START, lanes1..7 data. S4_TYPE gives lanes0..3 SYM_IDLE, lane4 SYM_START, lanes5..7 data.
- T: Tn_TYPE (n=0..7) gives lanes 0..n-1 data from payload bytes 1..n, lane n SYM_TERM, lanes n+1..7 SYM_IDLE.
- E: anything else, including sync 00/11, an unknown type, or a C_TYPE block with a non-idle code.
REQ-008 SHALL run the receive FSM {RX_INIT, RX_C, RX_D, RX_T, RX_E}, advancing once per decoded block:
- RX_INIT, RX_C, RX_T: C->RX_C, S->RX_D, else RX_E.
- RX_D: D->RX_D, T->RX_T, else RX_E.
- RX_E: C->RX_C, D->RX_D, T->RX_T, S->RX_D, E->RX_E.
REQ-009 SHALL output the decoded block when the next state is RX_C, RX_D or RX_T. When the next state is RX_E, it SHALL output ctrl=8'hFF and all lanes SYM_ERR.
REQ-010 SHALL increment o_err_cnt on each block whose next state is RX_E, saturating at 255 with no wrap.
REQ-011 When i_blk_lock is low at the decode transfer, it SHALL force the state to RX_INIT, output ctrl=8'hFF with lanes SYM_IDLE, and leave o_err_cnt unchanged.
REQ-012 When i_clk_en is low, it SHALL hold all registers. Outputs still follow i_trans_cnt.
REQ-013 SHALL be fully pipelined: a new block every N_TRANS_PER_BLK enabled cycles, with no stall path.

Reset
REQ-014 While i_reset_n==0 at a rising edge, regardless of i_clk_en:
- state <= RX_INIT
- stored slices and sync <= 0
- output register <= ctrl 8'hFF, lanes SYM_IDLE
- o_err_cnt <= 0
REQ-015 Reset asserted mid-block SHALL discard the partial block. Decoding restarts on the next i_trans_cnt==0 transfer.

Verification
REQ-016 Idle: lock=1, C blocks (C_TYPE, codes 0) for 4 blocks -> from block 2, every transfer ctrl=4'hF, data 07070707; state RX_C; err_cnt=0.
REQ-017 Frame: S0 block with bytes 55..55, then D block D5 01..07, then T3 block with 3 data bytes -> lanes FB 55..; D5 01..07; d,d,d,FD,07,07,07,07; ctrl masks 01,00,F8; no errors.
REQ-018 Bad sync: sync 2'b11 after a C block -> that output block is all FE, ctrl 8'hFF; err_cnt=1; state RX_E; next C block recovers to RX_C.
REQ-019 Sequence error: D block while in RX_C -> output all FE; err_cnt+1. 300 consecutive E blocks -> err_cnt holds at 255.
REQ-020 Lock/enable/reset: deassert i_blk_lock -> idle output, state RX_INIT. Toggle i_clk_en low mid-block -> output identical to the unstalled run. Pulse i_reset_n low between transfers -> idle output, err_cnt=0.
